// File: rtl/run_controller.sv
// run_controller
//   Run sequencer for the pipeline's cycle/instruction accounting. A start
//   pulse enables the pipeline (run). A halt at writeback drains in-flight
//   instructions for DRAIN_CYCLES more cycles and then freezes the counts in
//   DONE. A watchdog moves to TIMEOUT once cycle reaches MAX_CYCLES.
//
// Ports
//   clk, rst_n      : single rising-edge clock, async active-low reset
//   start           : begin a run (sampled in IDLE only)
//   clear           : leave DONE/TIMEOUT for IDLE
//   isHalt          : halt reached writeback (sampled in RUN only)
//   W_v             : one instruction retired this cycle
//   run             : pipeline enable (RUN, DRAIN)
//   done, timeout   : terminal state flags
//   state           : debug, IDLE=0 RUN=1 DRAIN=2 DONE=3 TIMEOUT=4
//   cycle, instrs   : counted cycles / retired instructions
module run_controller #(
    parameter int MAX_CYCLES   = 10000,
    parameter int DRAIN_CYCLES = 4,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear,
    input  logic               isHalt,
    input  logic               W_v,
    output logic               run,
    output logic               done,
    output logic               timeout,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] cycle,
    output logic [COUNT_W-1:0] instrs
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    localparam logic [COUNT_W-1:0] CYC_LIMIT = COUNT_W'(MAX_CYCLES);
    localparam logic [COUNT_W-1:0] INS_SAT   = '1;
    localparam logic [3:0]         DRAIN_LD  = 4'(DRAIN_CYCLES);

    logic [2:0]         state_q,  state_d;
    logic [COUNT_W-1:0] cycle_q,  cycle_d;
    logic [COUNT_W-1:0] instrs_q, instrs_d;
    logic [3:0]         drain_q,  drain_d;

    // Counter advance shared by RUN and DRAIN; instrs sticks at all-ones.
    logic [COUNT_W-1:0] cycle_inc;
    logic [COUNT_W-1:0] instrs_inc;
    logic               at_limit;

    always_comb begin
        cycle_inc  = cycle_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        instrs_inc = (instrs_q == INS_SAT) ? instrs_q
                   : instrs_q + {{(COUNT_W-1){1'b0}}, W_v};
        at_limit   = (cycle_q == CYC_LIMIT);
    end

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        instrs_d = instrs_q;
        drain_d  = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cycle_d  = '0;
                    instrs_d = '0;
                end
            end
            S_RUN: begin
                // Watchdog wins over halt: the limit edge is not counted.
                if (at_limit) begin
                    state_d = S_TIMEOUT;
                end else begin
                    cycle_d  = cycle_inc;
                    instrs_d = instrs_inc;
                    if (isHalt) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = DRAIN_LD;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (at_limit) begin
                    state_d = S_TIMEOUT;
                end else begin
                    cycle_d  = cycle_inc;
                    instrs_d = instrs_inc;
                    drain_d  = drain_q - 4'd1;
                    if (drain_q == 4'd1) state_d = S_DONE;
                end
            end
            S_DONE, S_TIMEOUT: begin
                // Counts survive the return to IDLE so they can still be read.
                if (clear) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cycle_q  <= '0;
            instrs_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            instrs_q <= instrs_d;
            drain_q  <= drain_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign run     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign timeout = (state_q == S_TIMEOUT);
    assign state   = state_q;
    assign cycle   = cycle_q;
    assign instrs  = instrs_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller. Three instances share the stimulus:
//   u0 defaults (MAX 10000, DRAIN 4), u1 zero drain (MAX 50, DRAIN 0),
//   u2 small watchdog (MAX 50, DRAIN 4). Each scenario starts from reset and
//   checks only the instance it targets.
module tb_run_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, clear = 1'b0, is_halt = 1'b0, w_v = 1'b0;

    logic        run_o  [3];
    logic        done_o [3];
    logic        tmo_o  [3];
    logic [2:0]  st_o   [3];
    logic [15:0] cyc_o  [3];
    logic [15:0] ins_o  [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_controller u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .isHalt(is_halt), .W_v(w_v),
        .run(run_o[0]), .done(done_o[0]), .timeout(tmo_o[0]), .state(st_o[0]),
        .cycle(cyc_o[0]), .instrs(ins_o[0]));

    run_controller #(.MAX_CYCLES(50), .DRAIN_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .isHalt(is_halt), .W_v(w_v),
        .run(run_o[1]), .done(done_o[1]), .timeout(tmo_o[1]), .state(st_o[1]),
        .cycle(cyc_o[1]), .instrs(ins_o[1]));

    run_controller #(.MAX_CYCLES(50), .DRAIN_CYCLES(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .isHalt(is_halt), .W_v(w_v),
        .run(run_o[2]), .done(done_o[2]), .timeout(tmo_o[2]), .state(st_o[2]),
        .cycle(cyc_o[2]), .instrs(ins_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse reset between edges and release well before the next edge.
    task automatic do_reset();
        start = 0; clear = 0; is_halt = 0; w_v = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        // ---- reset state
        tick();
        chk("rst_state", st_o[0], 0);
        chk("rst_run", run_o[0], 0);
        chk("rst_done", done_o[0], 0);
        chk("rst_tmo", tmo_o[0], 0);
        chk("rst_cycle", cyc_o[0], 0);
        chk("rst_instrs", ins_o[0], 0);
        do_reset();

        // ---- normal halt (u0): halt sampled at cycle 20 -> 4 drain edges -> 25/25
        tick();
        chk("idle_hold", st_o[0], 0);
        w_v = 1;
        pulse_start();
        chk("start_run", run_o[0], 1);
        chk("start_cycle", cyc_o[0], 0);
        tick(20);
        chk("pre_halt_cycle", cyc_o[0], 20);
        chk("pre_halt_state", st_o[0], 1);
        is_halt = 1;
        tick();
        is_halt = 0;
        chk("halt_to_drain", st_o[0], 2);
        chk("halt_cycle", cyc_o[0], 21);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("in_drain", st_o[0], 2);
            chk("drain_run", run_o[0], 1);
        end
        tick();
        chk("nh_state", st_o[0], 3);
        chk("nh_done", done_o[0], 1);
        chk("nh_run", run_o[0], 0);
        chk("nh_cycle", cyc_o[0], 25);
        chk("nh_instrs", ins_o[0], 25);
        tick(2);
        chk("done_frozen_cyc", cyc_o[0], 25);
        chk("done_frozen_ins", ins_o[0], 25);

        // ---- clear and start together in DONE: start is ignored
        start = 1; clear = 1;
        tick();
        start = 0; clear = 0;
        chk("clr_start_state", st_o[0], 0);
        chk("clr_keep_cycle", cyc_o[0], 25);
        tick();
        chk("idle_after_clr", st_o[0], 0);
        pulse_start();
        chk("restart_state", st_o[0], 1);
        chk("restart_cycle", cyc_o[0], 0);
        chk("restart_instrs", ins_o[0], 0);

        // ---- zero drain (u1): W_v 1,0,1,0..., halt at cycle 9 -> 10 cycles, 5 instrs
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            w_v = (i % 2 == 0);
            is_halt = (i == 9);
            if (i == 9) chk("zd_pre_cycle", cyc_o[1], 9);
            tick();
        end
        is_halt = 0; w_v = 0;
        chk("zd_state", st_o[1], 3);
        chk("zd_done", done_o[1], 1);
        chk("zd_cycle", cyc_o[1], 10);
        chk("zd_instrs", ins_o[1], 5);

        // ---- watchdog (u2), without and with a halt on the limit cycle
        for (int h = 0; h < 2; h++) begin
            do_reset();
            w_v = 1;
            pulse_start();
            tick(50);
            chk("wd_at_limit", cyc_o[2], 50);
            chk("wd_still_run", st_o[2], 1);
            is_halt = (h == 1);
            tick();
            is_halt = 0;
            chk(h ? "hl_state" : "wd_state", st_o[2], 4);
            chk(h ? "hl_done" : "wd_tmo", h ? done_o[2] : tmo_o[2], h ? 0 : 1);
            chk("wd_run", run_o[2], 0);
            chk("wd_cycle", cyc_o[2], 50);
            chk("wd_instrs", ins_o[2], 50);
        end
        pulse_start();
        chk("tmo_start_ign", st_o[2], 4);
        clear = 1;
        tick();
        clear = 0;
        chk("tmo_clear", st_o[2], 0);
        chk("tmo_clear_cyc", cyc_o[2], 50);

        // ---- async reset in DRAIN (u0)
        do_reset();
        w_v = 1;
        pulse_start();
        is_halt = 1;
        tick();
        is_halt = 0;
        chk("ar_in_drain", st_o[0], 2);
        chk("ar_pre_instrs", ins_o[0], 1);
        #2;
        rst_n = 0;
        #1;
        chk("ar_state", st_o[0], 0);
        chk("ar_run", run_o[0], 0);
        chk("ar_done", done_o[0], 0);
        chk("ar_tmo", tmo_o[0], 0);
        chk("ar_cycle", cyc_o[0], 0);
        chk("ar_instrs", ins_o[0], 0);
        tick(2);
        chk("ar_wv_ignored", ins_o[0], 0);
        w_v = 0;
        rst_n = 1;
        tick();
        chk("ar_release_idle", st_o[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Run sequencer for the pipelined processor's cycle/instruction accounting. It gates the pipeline's run enable from an external start pulse and counts clock cycles and retired instructions. On a halt it drains in-flight instructions for a fixed number of cycles, then freezes the counts. A watchdog stops the run at a cycle limit. It is synthesizable and replaces `$finish`-based run termination; the testbench reads `done`, `timeout`, `cycle` and `instrs`.

## Interface
- `MAX_CYCLES`, 10000: watchdog limit on counted cycles; must be < 2^`COUNT_W`.
- `DRAIN_CYCLES`, 4: pipeline cycles run after halt before stopping; range 0..15.
- `COUNT_W`, 16: width of the cycle and instruction counters.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a run; sampled only in IDLE.
- `clear`  in  1  returns DONE/TIMEOUT to IDLE.
- `isHalt`  in  1  halt instruction reached writeback; sampled only in RUN.
- `W_v`  in  1  writeback valid: one instruction retired this cycle.
- `run`  out  1  pipeline enable; 1 in RUN and DRAIN only.
- `done`  out  1  1 in DONE only.
- `timeout`  out  1  1 in TIMEOUT only.
- `state`  out  3  debug: IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4.
- `cycle`  out  `COUNT_W`  counted cycles.
- `instrs`  out  `COUNT_W`  retired instructions.

## Operation
- **Reset:**
  - Asserting `rst_n`=0 at any time forces state IDLE and sets `cycle`, `instrs` and the drain counter to 0.
  - It also sets `run`, `done` and `timeout` to 0.
  - All outputs are decoded from registers and change only on clock edges, except on async reset.
- **IDLE:**
  - `start`=1 → RUN; `cycle` and `instrs` are cleared to 0 on that edge.
  - Otherwise hold. `W_v` and `isHalt` are ignored.
- **RUN** (priority order at each edge):
  - If `cycle`==`MAX_CYCLES` → TIMEOUT; no increments.
  - Else if `isHalt`: `cycle`+1 and `instrs`+`W_v`. Go to DONE if `DRAIN_CYCLES`==0; otherwise load drain counter with `DRAIN_CYCLES` and go to DRAIN.
  - Else `cycle`+1, `instrs`+`W_v`.
- **DRAIN** (`isHalt` ignored):
  - If `cycle`==`MAX_CYCLES` → TIMEOUT.
  - Else `cycle`+1, `instrs`+`W_v`, drain counter −1; when the counter is 1 before decrement → DONE.
- **DONE / TIMEOUT:**
  - `run`=0; counters frozen; `start` ignored.
  - `clear`=1 → IDLE; counters keep their values until the next `start`.
- `start` in RUN/DRAIN is ignored. `clear` in IDLE/RUN/DRAIN is ignored.
- **Counter widths:**
  - `instrs` saturates at 2^`COUNT_W`−1.
  - `cycle` never exceeds `MAX_CYCLES`.
- Derived CPI = `cycle`/`instrs` is computed by the consumer; it is undefined when `instrs`=0.

## Timing
- `start` sampled at edge k → `run`=1 after edge k. The pipeline's first enabled cycle is k+1.
- Final `cycle` = H+1+`DRAIN_CYCLES`, where H is the `cycle` value in the cycle `isHalt` is sampled.
- `run` falls after the edge that enters DONE/TIMEOUT, in the same cycle `done`/`timeout` rises.
- `instrs` counts `W_v` on every RUN/DRAIN edge that increments `cycle`. It includes the halt edge; it excludes the timeout edge.
- Reset is asynchronous: outputs go to reset values without a clock edge, including mid-DRAIN.
- Deassertion of `rst_n` is synchronized externally; the first edge after release sees IDLE.

## Test plan
- **Normal halt:** defaults; `W_v`=1 constantly; `start` at edge 0; `isHalt` sampled when `cycle`=20 → `state` DRAIN for 4 edges, then `done`=1, `run`=0, `cycle`=25, `instrs`=25.
- **Zero drain:** `DRAIN_CYCLES`=0, `MAX_CYCLES`=50; `W_v` alternating 1,0; `isHalt` at `cycle`=9 → DONE on the next edge, `cycle`=10, `instrs`=5.
- **Watchdog:** `MAX_CYCLES`=50, `isHalt` never asserted → `timeout`=1, `cycle`=50, `run`=0; `start` afterwards is ignored; `clear` → `state`=0 and `cycle` stays 50.
- **Halt at limit:** `MAX_CYCLES`=50, `isHalt`=1 in the cycle `cycle`=50 → TIMEOUT (not DRAIN), `done`=0.
- **Simultaneous clear and start in DONE:** → IDLE with `start` ignored; a later `start` → RUN with `cycle`=0, `instrs`=0.
- **Async reset in DRAIN:** drive `rst_n`=0 between edges → `run`, `done`, `timeout`, `cycle`, `instrs` are 0 and `state`=0 immediately; a `W_v` pulse during reset leaves `instrs`=0.
